tim_seq_mul_add: RTL and testbench
==================================

TIM_SEQ_MUL_ADD -- requirements
Module: tim_seq_mul_add

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit, reset: asynchronous, active-low.
REQ-004 The module SHALL have port a, input, WIDTH bits, the first operand, sampled only at input handshake.
REQ-005 The module SHALL have port b, input, WIDTH bits, the second operand, sampled only at input handshake.
REQ-006 The module SHALL have port in_valid, input, 1 bit, asserted when the operands are valid.
REQ-007 The module SHALL have port in_ready, output, 1 bit, asserted when the block can accept operands.
REQ-008 The module SHALL have port sum, output, WIDTH bits, (a+b) mod 2^WIDTH.
REQ-009 The module SHALL have port carry, output, 1 bit, the carry-out of a+b.
REQ-010 The module SHALL have port product, output, 2*WIDTH bits, the full unsigned a*b.
REQ-011 The module SHALL have port out_valid, output, 1 bit, asserted when the results are valid.
REQ-012 The module SHALL have port out_ready, input, 1 bit, asserted when the consumer accepts the results.
REQ-013 The module SHALL have port busy, output, 1 bit, high in every state except IDLE.

Function
REQ-014 The module SHALL implement a three-state FSM: IDLE, MUL, DONE.
REQ-015 In IDLE the module SHALL drive in_ready=1; in MUL and DONE it SHALL drive in_ready=0.
REQ-016 Input handshake: in_valid && in_ready at a rising edge SHALL latch a and b, and clear the accumulator and the iteration counter.
REQ-017 At that same edge the module SHALL register sum and carry, and SHALL move to MUL.
REQ-018 In MUL, each edge SHALL perform one shift-add iteration: if multiplier bit 0 = 1, add the multiplicand to the accumulator; then shift the multiplicand left and the multiplier right.
REQ-019 The counter SHALL be $clog2(WIDTH)+1 bits wide, and iteration arithmetic SHALL be unsigned at 2*WIDTH bits with no overflow possible.
REQ-020 After exactly WIDTH iterations the module SHALL enter DONE, with no early termination on a zero operand; out_valid SHALL therefore rise WIDTH edges after the accepting edge.
REQ-021 In DONE the module SHALL drive out_valid=1, and sum, carry and product SHALL hold stable until out_valid && out_ready.
REQ-022 out_valid && out_ready at an edge SHALL return the FSM to IDLE and deassert out_valid; the output data values SHALL be retained.
REQ-023 in_valid while busy=1 SHALL be ignored, with no latching and no state change.
REQ-024 Throughput SHALL be at most one operation per WIDTH+2 cycles; there SHALL be no overlap of a new accept with DONE.
REQ-025 out_ready outside DONE SHALL have no effect.
REQ-026 All outputs SHALL be driven from registers or decoded directly from the state register, with no combinational path from inputs to outputs.
REQ-027 All sequential logic SHALL use nonblocking assignments in always_ff; next-state and decode logic SHALL use blocking assignments in always_comb.

Reset
REQ-028 On rst_n=0, at any time, the FSM SHALL go to IDLE, independent of clk.
REQ-029 During reset, sum, carry, product, out_valid, the accumulator, the counter and busy SHALL be 0, and in_ready SHALL be 1.
REQ-030 Reset asserted in MUL or DONE SHALL discard the operation in flight, with no out_valid pulse after release.
REQ-031 The first accept SHALL be possible at the first rising edge after rst_n deasserts.

Verification
REQ-032 a=3, b=4, in_valid pulse, out_ready=1 -> sum=7, carry=0, product=12; out_valid SHALL rise 8 edges after accept and last 1 cycle.
REQ-033 a=255, b=255 -> sum=0xFE, carry=1, product=0xFE01.
REQ-034 a=0, b=200 -> product=0, sum=200; latency SHALL still be 8 edges.
REQ-035 Hold out_ready=0 for 5 cycles in DONE -> out_valid and data SHALL stay stable; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-036 in_valid with a=9, b=9 asserted while in MUL -> ignored; the result SHALL be that of the original operands.
REQ-037 rst_n low at MUL iteration 4 -> all outputs 0 immediately; no out_valid after release; the next operation 5*6 SHALL give product=30.

Source files
------------

// File: rtl/tim_seq_mul_add.sv
// Sequential shift-add multiplier with a registered adder alongside.
// One operation in flight; valid/ready handshakes on both sides.
module tim_seq_mul_add #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   sum,
    output logic               carry,
    output logic [2*WIDTH-1:0] product,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    // Next-state and datapath: accept, iterate WIDTH times, then hold for the consumer
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        product_d = product_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d            = {{WIDTH{1'b0}}, a};
                    mplier_d           = b;
                    acc_d              = '0;
                    cnt_d              = '0;
                    {carry_d, sum_d}   = {1'b0, a} + {1'b0, b};
                    state_d            = MUL;
                end
            end
            MUL: begin
                acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // Always run all WIDTH iterations so latency is fixed
                if (cnt_q == CW'(WIDTH - 1)) begin
                    product_d = acc_d;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            product_q <= product_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign product   = product_q;

endmodule

// File: tb/tb_tim_seq_mul_add.sv
// Bench for tim_seq_mul_add: vector table through a scoreboard,
// plus back-pressure, busy-time input and mid-operation reset sequences.
module tb_tim_seq_mul_add;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   sum;
    logic           carry;
    logic [2*W-1:0] product;
    logic           out_valid;
    logic           out_ready;
    logic           busy;

    tim_seq_mul_add #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .carry     (carry),
        .product   (product),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [W-1:0]   s;
        logic           c;
        logic [2*W-1:0] p;
    } vec_t;

    typedef struct {
        logic [W-1:0]   s;
        logic           c;
        logic [2*W-1:0] p;
    } exp_t;

    vec_t vt[8];
    exp_t sb[$];
    int   n_cmp;
    int   n_bad;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one operation, check latency, results and handshake.
    // hold: cycles of out_ready=0 in DONE; inj: present 9*9 while in MUL.
    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input exp_t e, input int hold, input bit inj);
        int   lat;
        exp_t x;
        logic [W-1:0]   s0;
        logic           c0;
        logic [2*W-1:0] p0;
        chk("in_ready_before", 32'(in_ready), 32'd1);
        out_ready = (hold == 0);
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        sb.push_back(e);
        tick();
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        lat      = 0;
        while (!out_valid && lat < 40) begin
            if (inj && lat == 3) begin
                chk("in_ready_busy", 32'(in_ready), 32'd0);
                a        = 8'd9;
                b        = 8'd9;
                in_valid = 1'b1;
            end
            tick();
            lat++;
            if (inj && lat == 5) begin
                in_valid = 1'b0;
                a        = '0;
                b        = '0;
            end
        end
        if (!out_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: out_valid never rose");
            return;
        end
        chk("latency", 32'(lat), 32'(W));
        chk("busy_done", 32'(busy), 32'd1);
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: output with empty queue");
            return;
        end
        x = sb.pop_front();
        chk("sum", 32'(sum), 32'(x.s));
        chk("carry", 32'(carry), 32'(x.c));
        chk("product", 32'(product), 32'(x.p));
        s0 = sum;
        c0 = carry;
        p0 = product;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", {15'd0, c0, s0, p0}, {15'd0, carry, sum, product});
        end
        out_ready = 1'b1;
        tick();
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("in_ready_after", 32'(in_ready), 32'd1);
        chk("data_kept", {15'd0, c0, s0, p0}, {15'd0, carry, sum, product});
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({nm, "_data"}, {15'd0, carry, sum, product}, 32'd0);
    endtask

    initial begin
        exp_t e;
        int   seen;
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        a         = '0;
        b         = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        vt[0] = '{8'd3,   8'd4,   8'd7,   1'b0, 16'd12};
        vt[1] = '{8'd255, 8'd255, 8'hFE,  1'b1, 16'hFE01};
        vt[2] = '{8'd0,   8'd200, 8'd200, 1'b0, 16'd0};
        vt[3] = '{8'd200, 8'd0,   8'd200, 1'b0, 16'd0};
        vt[4] = '{8'd1,   8'd1,   8'd2,   1'b0, 16'd1};
        vt[5] = '{8'd128, 8'd2,   8'd130, 1'b0, 16'd256};
        vt[6] = '{8'd17,  8'd15,  8'd32,  1'b0, 16'd255};
        vt[7] = '{8'd255, 8'd1,   8'd0,   1'b1, 16'd255};

        #12;
        chk_reset_outs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First accept lands on the first edge after release
        for (int i = 0; i < 8; i++) begin
            e = '{vt[i].s, vt[i].c, vt[i].p};
            run_op(vt[i].a, vt[i].b, e, 0, 1'b0);
        end

        e = '{8'd103, 1'b0, 16'd300};
        run_op(8'd100, 8'd3, e, 5, 1'b0);

        e = '{8'd15, 1'b0, 16'd56};
        run_op(8'd7, 8'd8, e, 0, 1'b1);

        // Reset at MUL iteration 4 discards the operation
        a        = 8'd100;
        b        = 8'd100;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_sum", 32'(sum), 32'd200);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("no_ghost_valid", 32'(seen), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        e = '{8'd11, 1'b0, 16'd30};
        run_op(8'd5, 8'd6, e, 0, 1'b0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
